// File: rtl/reg_file_sb.sv
// reg_file_sb: general-purpose register file with per-register scoreboard.
//
// Purpose:
//   NUM_READ combinational read ports, one writeback port and a busy bit per
//   register so that issue logic can stall on RAW hazards. Register 0 reads
//   as zero and is never busy.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   raddr_i      : packed read addresses, port k at [k*AW +: AW]
//   rdata_o      : packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   hazard_o     : per read port, source register has a pending producer
//   wen_i/waddr_i/wdata_i : writeback; clears the busy bit of waddr_i
//   rsv_en_i/rsv_addr_i   : reserve (mark busy) a destination at issue
//   rsv_ok_o     : rsv_addr_i is currently free
//   flush_i      : clear every busy bit; same-cycle reserve is ignored
//   busy_cnt_o   : registered count of busy registers
//
// Build option:
//   REG_FILE_SB_BYPASS_EN - forward the in-flight writeback to matching read
//   ports (data and hazard) and to rsv_ok_o in the same cycle.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int NUM_READ   = 2,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*AW-1:0]         raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_READ-1:0]            hazard_o,
    input  logic                           wen_i,
    input  logic [AW-1:0]                  waddr_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic                           rsv_en_i,
    input  logic [AW-1:0]                  rsv_addr_i,
    output logic                           rsv_ok_o,
    input  logic                           flush_i,
    output logic [AW:0]                    busy_cnt_o
);

    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q, busy_d;
    logic [CW-1:0]         busy_cnt_q, busy_cnt_d;
    logic                  wr_act;
    logic                  rsv_act;

    assign wr_act  = wen_i && (waddr_i != '0);
    assign rsv_act = rsv_en_i && (rsv_addr_i != '0) && !flush_i;

    // Reserve is applied after the write clear so a same-cycle reserve of the
    // written register leaves it busy (a newer producer is in flight).
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (wr_act) begin
                busy_d[waddr_i] = 1'b0;
            end
            if (rsv_act) begin
                busy_d[rsv_addr_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Count is taken from the next-state vector so it lands on the same edge
    // as the busy bits and can never double count a repeated reserve.
    always_comb begin
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            busy_cnt_d = busy_cnt_d + CW'(busy_d[AW'(i)]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else if (wr_act) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o  = '0;
        hazard_o = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            if (raddr_i[k*AW +: AW] != '0) begin
                rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_i[k*AW +: AW]];
            end
            hazard_o[k] = busy_q[raddr_i[k*AW +: AW]];
`ifdef REG_FILE_SB_BYPASS_EN
            if (wr_act && (raddr_i[k*AW +: AW] == waddr_i)) begin
                rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_i;
                hazard_o[k] = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        rsv_ok_o = !busy_q[rsv_addr_i];
`ifdef REG_FILE_SB_BYPASS_EN
        if (wr_act && (rsv_addr_i == waddr_i)) begin
            rsv_ok_o = 1'b1;
        end
`endif
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  hazard;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic        rsv_ok;
    logic        flush = 1'b0;
    logic [5:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state: plain arrays updated from the behavioural rules.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_cnt;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(32), .REG_COUNT(32), .NUM_READ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr_i    (raddr),
        .rdata_o    (rdata),
        .hazard_o   (hazard),
        .wen_i      (wen),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .rsv_ok_o   (rsv_ok),
        .flush_i    (flush),
        .busy_cnt_o (busy_cnt)
    );

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_edge();
        if (wen && waddr != 0) m_mem[waddr] = wdata;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (wen && waddr != 0) m_busy[waddr] = 1'b0;
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
    endfunction

    function automatic bit fwd(input logic [4:0] a);
`ifdef REG_FILE_SB_BYPASS_EN
        return wen && waddr != 0 && a == waddr;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (fwd(a)) return wdata;
        return (a == 0) ? 32'h0 : m_mem[a];
    endfunction

    function automatic logic exp_hz(input logic [4:0] a);
        if (fwd(a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ok(input logic [4:0] a);
        if (fwd(a)) return 1'b1;
        return !m_busy[a];
    endfunction

    // Drive a full input vector just after the falling edge, then settle.
    task automatic drive(input logic [4:0] r0, input logic [4:0] r1,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rs, input logic [4:0] ra, input logic fl);
        @(negedge clk);
        raddr = {r1, r0};
        wen = w; waddr = wa; wdata = wd;
        rsv_en = rs; rsv_addr = ra; flush = fl;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(5'd0, 5'd5, 0, 0, 0, 0, 5'd31, 0);
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata_0_5 got=%h exp=0", rdata); end
        checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL reset_hazard got=%b exp=00", hazard); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
        checks++; if (rsv_ok !== 1'b1) begin errors++; $display("FAIL reset_rsv_ok got=%b exp=1", rsv_ok); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'd31, 5'd0, 0, 0, 0, 0, 5'd31, 0);
        checks++; if (rdata[31:0] !== 32'h0 || hazard !== 2'b00) begin
            errors++; $display("FAIL reset_x31 got=%h/%b exp=0/00", rdata[31:0], hazard);
        end
    endtask

    task automatic test_write();
        drive(5'd0, 5'd0, 1, 5'd7, 32'hDEADBEEF, 0, 0, 0);
        tick();
        drive(5'd7, 5'd0, 1, 5'd0, 32'h1234, 0, 0, 0);
        checks++; if (rdata[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_x7 got=%h exp=deadbeef", rdata[31:0]); end
        tick();
        drive(5'd0, 5'd7, 0, 0, 0, 0, 0, 0);
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL write_x0_dropped got=%h exp=0", rdata[31:0]); end
        checks++; if (rdata[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_x7_port1 got=%h exp=deadbeef", rdata[63:32]); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL write_cnt got=%0d exp=0", busy_cnt); end
    endtask

    task automatic test_reserve();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd3, 0);
        checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL rsv_latency got=%b exp=00", hazard); end
        tick();
        drive(5'd3, 5'd0, 0, 0, 0, 0, 5'd3, 0);
        checks++; if (hazard !== 2'b01) begin errors++; $display("FAIL rsv_hazard got=%b exp=01", hazard); end
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL rsv_cnt got=%0d exp=1", busy_cnt); end
        checks++; if (rsv_ok !== 1'b0) begin errors++; $display("FAIL rsv_ok_busy got=%b exp=0", rsv_ok); end
        drive(5'd3, 5'd0, 1, 5'd3, 32'hA5, 0, 5'd3, 0);
        checks++; if (hazard[0] !== exp_hz(5'd3) || rdata[31:0] !== exp_rd(5'd3)) begin
            errors++; $display("FAIL rsv_wr_same_cycle got=%b/%h exp=%b/%h", hazard[0], rdata[31:0], exp_hz(5'd3), exp_rd(5'd3));
        end
        tick();
        drive(5'd3, 5'd0, 0, 0, 0, 0, 5'd3, 0);
        checks++; if (hazard !== 2'b00 || busy_cnt !== 6'd0 || rdata[31:0] !== 32'hA5) begin
            errors++; $display("FAIL rsv_release got=%b/%0d/%h exp=00/0/a5", hazard, busy_cnt, rdata[31:0]);
        end
    endtask

    task automatic test_same_cycle();
        drive(5'd0, 5'd0, 1, 5'd4, 32'h55, 1, 5'd4, 0);
        tick();
        drive(5'd4, 5'd0, 0, 0, 0, 0, 5'd4, 0);
        checks++; if (rdata[31:0] !== 32'h55 || hazard[0] !== 1'b1) begin
            errors++; $display("FAIL rsv_wins got=%h/%b exp=55/1", rdata[31:0], hazard[0]);
        end
        checks++; if (busy_cnt !== 6'd1 || rsv_ok !== 1'b0) begin
            errors++; $display("FAIL rsv_wins_cnt got=%0d/%b exp=1/0", busy_cnt, rsv_ok);
        end
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd3, 0);
        tick();
        drive(5'd0, 5'd0, 1, 5'd3, 32'h99, 1, 5'd8, 0);
        tick();
        drive(5'd8, 5'd3, 0, 0, 0, 0, 0, 0);
        checks++; if (busy_cnt !== 6'd2 || hazard !== 2'b01) begin
            errors++; $display("FAIL swap_busy got=%0d/%b exp=2/01", busy_cnt, hazard);
        end
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd8, 0);
        tick();
        drive(5'd8, 5'd0, 0, 0, 0, 0, 0, 0);
        checks++; if (busy_cnt !== 6'd2) begin errors++; $display("FAIL double_rsv_cnt got=%0d exp=2", busy_cnt); end
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0);
        tick();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        checks++; if (busy_cnt !== 6'd2 || hazard !== 2'b00 || rsv_ok !== 1'b1) begin
            errors++; $display("FAIL rsv_x0 got=%0d/%b/%b exp=2/00/1", busy_cnt, hazard, rsv_ok);
        end
    endtask

    task automatic test_flush();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd1, 0); tick();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd2, 0); tick();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd9, 0); tick();
        drive(5'd1, 5'd9, 1, 5'd2, 32'h77, 1, 5'd10, 1);
        checks++; if (busy_cnt !== 6'd5 || hazard !== 2'b11) begin
            errors++; $display("FAIL pre_flush got=%0d/%b exp=5/11", busy_cnt, hazard);
        end
        tick();
        drive(5'd2, 5'd10, 0, 0, 0, 0, 5'd10, 0);
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", busy_cnt); end
        checks++; if (hazard !== 2'b00 || rsv_ok !== 1'b1) begin
            errors++; $display("FAIL flush_rsv_ignored got=%b/%b exp=00/1", hazard, rsv_ok);
        end
        checks++; if (rdata[31:0] !== 32'h77) begin errors++; $display("FAIL flush_write got=%h exp=77", rdata[31:0]); end
    endtask

    task automatic test_bypass();
        drive(5'd0, 5'd0, 1, 5'd6, 32'h1111, 0, 0, 0); tick();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd6, 0); tick();
        drive(5'd0, 5'd6, 1, 5'd6, 32'hCAFE, 0, 5'd6, 0);
`ifdef REG_FILE_SB_BYPASS_EN
        checks++; if (rdata[63:32] !== 32'hCAFE || hazard[1] !== 1'b0 || rsv_ok !== 1'b1) begin
            errors++; $display("FAIL bypass_fwd got=%h/%b/%b exp=cafe/0/1", rdata[63:32], hazard[1], rsv_ok);
        end
`else
        checks++; if (rdata[63:32] !== 32'h1111 || hazard[1] !== 1'b1 || rsv_ok !== 1'b0) begin
            errors++; $display("FAIL no_bypass_old got=%h/%b/%b exp=1111/1/0", rdata[63:32], hazard[1], rsv_ok);
        end
`endif
        tick();
        drive(5'd0, 5'd6, 0, 0, 0, 0, 0, 0);
        checks++; if (rdata[63:32] !== 32'hCAFE || hazard[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_after got=%h/%b exp=cafe/0", rdata[63:32], hazard[1]);
        end
    endtask

    task automatic test_async_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 1, 5'd12, 0); tick();
        drive(5'd7, 5'd12, 0, 0, 0, 0, 5'd12, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (busy_cnt !== 6'd0 || hazard !== 2'b00 || rdata !== 64'h0 || rsv_ok !== 1'b1) begin
            errors++; $display("FAIL async_reset got=%0d/%b/%h/%b exp=0/00/0/1", busy_cnt, hazard, rdata, rsv_ok);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] r0, r1, wa, ra;
        for (int n = 0; n < 400; n++) begin
            r0 = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 31));
            wa = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            drive(r0, r1, 1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ra,
                  ($urandom_range(0, 19) == 0));
            checks++; if (rdata[31:0] !== exp_rd(r0) || rdata[63:32] !== exp_rd(r1)) begin
                errors++; $display("FAIL rand_rdata n=%0d got=%h exp=%h_%h", n, rdata, exp_rd(r1), exp_rd(r0));
            end
            checks++; if (hazard !== {exp_hz(r1), exp_hz(r0)} || rsv_ok !== exp_ok(ra)) begin
                errors++; $display("FAIL rand_hazard n=%0d got=%b/%b exp=%b%b/%b", n, hazard, rsv_ok, exp_hz(r1), exp_hz(r0), exp_ok(ra));
            end
            checks++; if (int'(busy_cnt) !== m_cnt) begin
                errors++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, busy_cnt, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_reserve();
        test_same_cycle();
        test_flush();
        test_bypass();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's GP register file.
- Provides NUM_READ combinational read ports, one write port, and a per-register scoreboard (busy bits) so issue logic can stall on RAW hazards.
- Sits between decode/issue and the writeback stage.
- Register 0 is hardwired to zero and is never busy.

Parameters:
DATA_WIDTH, 32, width of each register
REG_COUNT, 32, number of registers (power of two, >= 2)
NUM_READ, 2, number of read ports (1..4)
AW, $clog2(REG_COUNT), address width (derived, do not override)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
raddr_i  input  NUM_READ*AW  packed read addresses; port k is bits [k*AW +: AW]
rdata_o  output  NUM_READ*DATA_WIDTH  packed read data; port k is bits [k*DATA_WIDTH +: DATA_WIDTH]
hazard_o  output  NUM_READ  port k source register is busy (pending producer)
wen_i  input  1  writeback enable
waddr_i  input  AW  writeback address
wdata_i  input  DATA_WIDTH  writeback data
rsv_en_i  input  1  reserve destination (mark busy) at issue
rsv_addr_i  input  AW  register to reserve
rsv_ok_o  output  1  rsv_addr_i is not currently busy (WAW-free)
flush_i  input  1  clear all busy bits (pipeline flush)
busy_cnt_o  output  AW+1  number of busy registers

Behaviour:
- Reset (rst_n=0, asynchronous): all registers = 0, all busy bits = 0, busy_cnt_o = 0. Combinational outputs follow from the cleared state: hazard_o = 0, rsv_ok_o = 1, rdata_o = 0.
- Reads:
  - Combinational: rdata for port k = mem[raddr k].
  - Address 0 always reads 0.
  - hazard_o[k] = busy[raddr k].
- Write:
  - On posedge with wen_i=1 and waddr_i!=0: mem[waddr_i] <= wdata_i and busy[waddr_i] <= 0.
  - Writes to address 0 are dropped.
- Reserve:
  - On posedge with rsv_en_i=1, rsv_addr_i!=0 and flush_i=0: busy[rsv_addr_i] <= 1.
  - Reserve of address 0 is a no-op.
- rsv_ok_o = !busy[rsv_addr_i] (combinational). Issue logic must not assert rsv_en_i when rsv_ok_o=0. If it does, busy stays 1 and busy_cnt_o is unchanged (no double count).
- Same-cycle reserve and write to the same address: reserve wins; mem is updated and busy ends at 1 (a newer producer is in flight).
- Flush:
  - flush_i=1: all busy bits <= 0 at the next edge and any same-cycle reserve is ignored.
  - A same-cycle write still updates mem.
- busy_cnt_o:
  - Registered popcount of the busy vector, updated on the same edge as the busy bits.
  - Per cycle it changes by at most +1 (reserve of a free register), -1 (write to a busy register), 0 (both, different addresses), or goes to 0 on flush.
  - Never exceeds REG_COUNT-1.
- Latency:
  - A write is visible on rdata_o the cycle after the edge (without the optional feature).
  - A reserve raises hazard_o the cycle after the edge.
- Same-cycle read and write to the same address without bypass: old data is returned and hazard_o reflects the old busy value.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Enabled:
  - A read port whose address equals waddr_i while wen_i=1 and waddr_i!=0 returns wdata_i in the same cycle and forces its hazard_o to 0.
  - rsv_ok_o is forced to 1 when rsv_addr_i equals an active write address.
  - Exception: a same-cycle reserve to that address still leaves busy=1 after the edge.
- Disabled: no forwarding; behaviour exactly as in Behaviour.

Test Plan:
1. Reset, then read ports at addresses 0, 5 and 31 -> rdata=0, hazard_o=0, busy_cnt_o=0, rsv_ok_o=1.
2. Write 0xDEADBEEF to x7, read x7 next cycle -> 0xDEADBEEF. Write 0x1234 to x0 -> x0 still reads 0.
3. Reserve x3 -> hazard_o=1 for a port reading x3, busy_cnt_o=1, rsv_ok_o=0 for x3. Write 0xA5 to x3 -> hazard_o=0, busy_cnt_o=0, data 0xA5.
4. Same cycle: reserve x4 and write 0x55 to x4 (x4 not busy) -> x4 reads 0x55, busy[x4]=1, busy_cnt_o=1. Same cycle: reserve x8 and write x3 (x3 busy) -> busy_cnt_o unchanged.
5. Reserve x1, x2, x9. Then flush with a simultaneous reserve of x10 and a write of 0x77 to x2 -> busy_cnt_o=0, x10 not busy, x2 reads 0x77.
6. With REG_FILE_SB_BYPASS_EN defined: write 0xCAFE to x6 while port 1 reads x6 -> rdata port 1 = 0xCAFE and hazard_o[1]=0 in the same cycle. Without the macro -> old value returned.
